// File: rtl/turbo_pkg.sv
// Shared definitions for the LTE-style QPP turbo interleaver.
//   state_t     : controller states (IDLE/LOAD/EMIT/GAP)
//   K_SHORT/LONG: supported block sizes
//   F1_*/F2_*   : QPP polynomial coefficients per block size
//   IDX_W/SUM_W : index width and width of a pre-modulo sum
//   k_last()    : last valid index for a given size flag
//   mod_sub()   : single conditional subtract of K
package turbo_pkg;

   localparam int IDX_W    = 13;
   localparam int SUM_W    = IDX_W + 1;
   localparam int K_SHORT  = 1056;
   localparam int K_LONG   = 6144;
   localparam int F1_SHORT = 17;
   localparam int F2_SHORT = 66;
   localparam int F1_LONG  = 263;
   localparam int F2_LONG  = 480;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   function automatic logic [IDX_W-1:0] k_last(input logic len);
      return len ? IDX_W'(K_LONG - 1) : IDX_W'(K_SHORT - 1);
   endfunction

   // Operands are always < K, so a sum is < 2K and one subtract suffices.
   function automatic logic [IDX_W-1:0] mod_sub(input logic [SUM_W-1:0] sum,
                                                 input logic [SUM_W-1:0] k);
      logic [SUM_W-1:0] r;
      r = (sum >= k) ? (sum - k) : sum;
      return r[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Multiplier-free QPP address generator: pi(i) = (f1*i + f2*i^2) mod K.
//   clk     : clock
//   rst     : asynchronous active-low reset (pi=0, g=0)
//   init_i  : load pi=0, g=(f1+f2) mod K for the size given by len_i
//   step_i  : advance to the next index
//   len_i   : block size flag (0: K=1056, 1: K=6144)
//   pi_o    : current interleaved address
module qpp_addr_gen
   import turbo_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             init_i,
   input  logic             step_i,
   input  logic             len_i,
   output logic [IDX_W-1:0] pi_o
);

   logic [IDX_W-1:0] pi_q, pi_d;
   logic [IDX_W-1:0] g_q, g_d;
   logic [SUM_W-1:0] k_w, g0_w, d2_w;

   always_comb begin
      k_w  = len_i ? SUM_W'(K_LONG)            : SUM_W'(K_SHORT);
      g0_w = len_i ? SUM_W'(F1_LONG + F2_LONG) : SUM_W'(F1_SHORT + F2_SHORT);
      d2_w = len_i ? SUM_W'(2 * F2_LONG)       : SUM_W'(2 * F2_SHORT);
      pi_d = pi_q;
      g_d  = g_q;
      if (init_i) begin
         pi_d = '0;
         g_d  = mod_sub(g0_w, k_w);
      end else if (step_i) begin
         // pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*f2, both mod K
         pi_d = mod_sub({1'b0, pi_q} + {1'b0, g_q}, k_w);
         g_d  = mod_sub({1'b0, g_q} + d2_w, k_w);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pi_q <= '0;
         g_q  <= '0;
      end else begin
         pi_q <= pi_d;
         g_q  <= g_d;
      end
   end

   assign pi_o = pi_q;

endmodule

// File: rtl/turbo_interleaver.sv
// Turbo interleaver: buffers one block in natural order, then streams
// c(i) and c(pi(i)) for i = 0..K-1.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   in_valid   : input bit qualifier
//   in_bit     : systematic bit, natural order
//   in_length  : size select (0: K=1056, 1: K=6144), latched on first bit
//   bypass     : only with TURBO_INTLV_BYPASS_EN; latched with in_length,
//                1 makes ckp follow ck for the whole block
//   in_ready   : high in IDLE/LOAD
//   data_valid : high for K consecutive cycles per block
//   ck / ckp   : natural / interleaved bit, 0 when data_valid is low
//   length     : latched size flag
//   busy       : high in LOAD, EMIT, GAP
//
// state   | meaning
// IDLE    | waiting for the first bit of a block
// LOAD    | writing bits 1..K-1 into the buffer
// EMIT    | streaming K output pairs, then one cycle to clear outputs
// GAP     | one idle cycle with data_valid low before accepting again
module turbo_interleaver
   import turbo_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic in_bit,
   input  logic in_length,
`ifdef TURBO_INTLV_BYPASS_EN
   input  logic bypass,
`endif
   output logic in_ready,
   output logic data_valid,
   output logic ck,
   output logic ckp,
   output logic length,
   output logic busy
);

   state_t           state_q;
   logic [IDX_W-1:0] wr_idx_q, rd_idx_q, last_idx, pi_w;
   logic             length_q, dv_q, ck_q, ckp_q, last_q, byp_q;
   logic             accept, gen_init, gen_step;
   logic             mem [K_LONG];

   assign in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign busy     = (state_q != ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign last_idx = k_last(length_q);
   assign gen_init = accept && (state_q == ST_LOAD) && (wr_idx_q == last_idx);
   assign gen_step = (state_q == ST_EMIT) && !last_q;

   qpp_addr_gen u_addr (
      .clk    (clk),
      .rst    (rst),
      .init_i (gen_init),
      .step_i (gen_step),
      .len_i  (length_q),
      .pi_o   (pi_w)
   );

   // Block storage is never reset; a discarded block is simply overwritten.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_idx_q] <= in_bit;
   end

`ifdef TURBO_INTLV_BYPASS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             byp_q <= 1'b0;
      else if (accept && state_q == ST_IDLE) byp_q <= bypass;
   end
`else
   assign byp_q = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         length_q <= 1'b0;
         dv_q     <= 1'b0;
         ck_q     <= 1'b0;
         ckp_q    <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  wr_idx_q <= IDX_W'(1);
                  length_q <= in_length;
                  state_q  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  if (wr_idx_q == last_idx) begin
                     wr_idx_q <= '0;
                     state_q  <= ST_EMIT;
                  end else begin
                     wr_idx_q <= wr_idx_q + IDX_W'(1);
                  end
               end
            end
            ST_EMIT: begin
               if (last_q) begin
                  // last pair has been on the outputs for one cycle
                  last_q  <= 1'b0;
                  dv_q    <= 1'b0;
                  ck_q    <= 1'b0;
                  ckp_q   <= 1'b0;
                  state_q <= ST_GAP;
               end else begin
                  dv_q  <= 1'b1;
                  ck_q  <= mem[rd_idx_q];
                  ckp_q <= byp_q ? mem[rd_idx_q] : mem[pi_w];
                  if (rd_idx_q == last_idx) begin
                     rd_idx_q <= '0;
                     last_q   <= 1'b1;
                  end else begin
                     rd_idx_q <= rd_idx_q + IDX_W'(1);
                  end
               end
            end
            ST_GAP: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_valid = dv_q;
   assign ck         = ck_q;
   assign ckp        = ckp_q;
   assign length     = length_q;

endmodule

// File: tb/tb_turbo_interleaver.sv
module tb_turbo_interleaver;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic in_length = 1'b0;
   logic bypass = 1'b0;
   logic in_ready, data_valid, ck, ckp, length, busy;

   always #5 clk = ~clk;

   turbo_interleaver dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .in_length  (in_length),
`ifdef TURBO_INTLV_BYPASS_EN
      .bypass     (bypass),
`endif
      .in_ready   (in_ready),
      .data_valid (data_valid),
      .ck         (ck),
      .ckp        (ckp),
      .length     (length),
      .busy       (busy)
   );

   typedef struct {
      bit ck;
      bit ckp;
      bit len;
   } exp_t;

   exp_t q[$];
   bit   blk [0:6143];
   int   vectors = 0;
   int   miscompares = 0;
   int   run_cnt = 0, last_run = 0, runs_done = 0;
   int   pop_cnt = 0, ck_ones = 0, ckp_ones = 0, ck_idx = -1, ckp_idx = -1;
   logic gap_busy, gap_rdy;

   // Scoreboard: pops one expected pair per valid output cycle.
   always @(negedge clk) begin
      exp_t e;
      if (data_valid === 1'b1) begin
         run_cnt++;
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_extra: output at i=%0d got ck=%b ckp=%b, none expected",
                     pop_cnt, ck, ckp);
         end else begin
            e = q.pop_front();
            if ({ck, ckp, length} !== {e.ck, e.ckp, e.len}) begin
               miscompares++;
               $display("FAIL sb_data i=%0d: got ck/ckp/len=%b%b%b want %b%b%b",
                        pop_cnt, ck, ckp, length, e.ck, e.ckp, e.len);
            end
         end
         if (ck === 1'b1)  begin ck_ones++;  ck_idx  = pop_cnt; end
         if (ckp === 1'b1) begin ckp_ones++; ckp_idx = pop_cnt; end
         pop_cnt++;
      end else if (run_cnt > 0) begin
         vectors++;
         if ({ck, ckp} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_zero: got ck/ckp=%b%b want 00", ck, ckp);
         end
         gap_busy  = busy;
         gap_rdy   = in_ready;
         last_run  = run_cnt;
         run_cnt   = 0;
         runs_done++;
      end
   end

   task automatic clear_stats();
      pop_cnt = 0; ck_ones = 0; ckp_ones = 0; ck_idx = -1; ckp_idx = -1;
   endtask

   task automatic push_expected(input int k, input bit len, input bit byp);
      exp_t   e;
      longint f1, f2, ii, p;
      f1 = len ? 263 : 17;
      f2 = len ? 480 : 66;
      for (int i = 0; i < k; i++) begin
         ii    = i;
         p     = (f1 * ii + f2 * ii * ii) % k;
         e.ck  = blk[i];
         e.ckp = byp ? blk[i] : blk[int'(p)];
         e.len = len;
         q.push_back(e);
      end
   endtask

   task automatic load_block(input int k, input bit len, input bit pause, input bit flip);
      int idx;
      idx = 0;
      while (idx < k) begin
         @(negedge clk);
         if (pause && $urandom_range(0, 1) == 0) begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom);
         end else begin
            in_valid = 1'b1;
            in_bit   = blk[idx];
            idx++;
         end
         in_length = (flip && idx > 1) ? ~len : len;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_run(input int budget, output bit done);
      int snap;
      snap = runs_done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(posedge clk);
         if (runs_done != snap) done = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({data_valid, ck, ckp, length, busy, in_ready} !== 6'b000001) begin
         miscompares++;
         $display("FAIL reset_outputs: got dv,ck,ckp,len,busy,rdy=%b want 000001",
                  {data_valid, ck, ckp, length, busy, in_ready});
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_83();
      bit done;
      foreach (blk[i]) blk[i] = 1'b0;
      blk[83] = 1'b1;
      clear_stats();
      push_expected(1056, 1'b0, 1'b0);
      load_block(1056, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({in_ready, busy, data_valid} !== 3'b010) begin
         miscompares++;
         $display("FAIL after_last_bit: got rdy,busy,dv=%b want 010", {in_ready, busy, data_valid});
      end
      @(negedge clk);
      vectors++;
      if (data_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL first_valid_latency: got dv=%b want 1", data_valid);
      end
      wait_run(1200, done);
      vectors++;
      if (!done || last_run != 1056) begin
         miscompares++;
         $display("FAIL run_len_83: got %0d (done=%0d) want 1056", last_run, done);
      end
      vectors++;
      if (ckp_ones != 1 || ckp_idx != 1) begin
         miscompares++;
         $display("FAIL ckp_one_83: got count=%0d idx=%0d want 1 at 1", ckp_ones, ckp_idx);
      end
      vectors++;
      if (ck_ones != 1 || ck_idx != 83) begin
         miscompares++;
         $display("FAIL ck_one_83: got count=%0d idx=%0d want 1 at 83", ck_ones, ck_idx);
      end
      vectors++;
      if ({in_ready, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL back_to_idle: got rdy,busy=%b want 10", {in_ready, busy});
      end
   endtask

   task automatic test_single_298();
      bit done;
      foreach (blk[i]) blk[i] = 1'b0;
      blk[298] = 1'b1;
      clear_stats();
      push_expected(1056, 1'b0, 1'b0);
      load_block(1056, 1'b0, 1'b0, 1'b0);
      wait_run(1200, done);
      vectors++;
      if (!done || last_run != 1056) begin
         miscompares++;
         $display("FAIL run_len_298: got %0d (done=%0d) want 1056", last_run, done);
      end
      vectors++;
      if ({gap_busy, gap_rdy} !== 2'b10) begin
         miscompares++;
         $display("FAIL gap_cycle: got busy,rdy=%b want 10", {gap_busy, gap_rdy});
      end
      vectors++;
      if (ckp_ones != 1 || ckp_idx != 2) begin
         miscompares++;
         $display("FAIL ckp_one_298: got count=%0d idx=%0d want 1 at 2", ckp_ones, ckp_idx);
      end
   endtask

   task automatic test_long_random();
      bit done;
      foreach (blk[i]) blk[i] = 1'($urandom);
      clear_stats();
      push_expected(6144, 1'b1, 1'b0);
      load_block(6144, 1'b1, 1'b0, 1'b0);
      wait_run(6300, done);
      vectors++;
      if (!done || last_run != 6144) begin
         miscompares++;
         $display("FAIL run_len_long: got %0d (done=%0d) want 6144", last_run, done);
      end
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_left_long: got %0d pending want 0", q.size());
      end
   endtask

   task automatic test_paused_load();
      bit done;
      foreach (blk[i]) blk[i] = 1'($urandom);
      clear_stats();
      push_expected(1056, 1'b0, 1'b0);
      load_block(1056, 1'b0, 1'b1, 1'b1);
      // traffic during EMIT must not reach the buffer
      for (int c = 0; c < 300; c++) begin
         in_valid = 1'b1;
         in_bit   = 1'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_run(1200, done);
      vectors++;
      if (!done || last_run != 1056) begin
         miscompares++;
         $display("FAIL run_len_paused: got %0d (done=%0d) want 1056", last_run, done);
      end
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_left_paused: got %0d pending want 0", q.size());
      end
      in_length = 1'b0;
   endtask

   task automatic test_reset_mid_emit();
      bit done;
      int c;
      foreach (blk[i]) blk[i] = 1'($urandom);
      clear_stats();
      push_expected(1056, 1'b0, 1'b0);
      load_block(1056, 1'b0, 1'b0, 1'b0);
      c = 0;
      while (pop_cnt < 500 && c < 700) begin
         @(posedge clk);
         c++;
      end
      vectors++;
      if (pop_cnt < 500) begin
         miscompares++;
         $display("FAIL reach_500: got %0d outputs want 500", pop_cnt);
      end
      #1 rst = 1'b0;
      #1;
      vectors++;
      if ({data_valid, ck, ckp, busy, in_ready, length} !== 6'b000010) begin
         miscompares++;
         $display("FAIL reset_mid_emit: got dv,ck,ckp,busy,rdy,len=%b want 000010",
                  {data_valid, ck, ckp, busy, in_ready, length});
      end
      q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      foreach (blk[i]) blk[i] = 1'($urandom);
      clear_stats();
      push_expected(1056, 1'b0, 1'b0);
      load_block(1056, 1'b0, 1'b0, 1'b0);
      wait_run(1200, done);
      vectors++;
      if (!done || last_run != 1056 || q.size() != 0) begin
         miscompares++;
         $display("FAIL after_reset_block: got run=%0d pending=%0d want 1056 and 0",
                  last_run, q.size());
      end
   endtask

`ifdef TURBO_INTLV_BYPASS_EN
   task automatic test_bypass();
      bit done;
      foreach (blk[i]) blk[i] = 1'($urandom);
      clear_stats();
      bypass = 1'b1;
      push_expected(1056, 1'b0, 1'b1);
      load_block(1056, 1'b0, 1'b0, 1'b0);
      bypass = 1'b0;
      wait_run(1200, done);
      vectors++;
      if (!done || last_run != 1056 || q.size() != 0) begin
         miscompares++;
         $display("FAIL bypass_block: got run=%0d pending=%0d want 1056 and 0",
                  last_run, q.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_83();
      test_single_298();
      test_long_random();
      test_paused_load();
      test_reset_mid_emit();
`ifdef TURBO_INTLV_BYPASS_EN
      test_bypass();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/turbo_interleaver.md
TURBO_INTERLEAVER -- requirements
Module: turbo_interleaver

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: qualifies in_bit in LOAD.
REQ-004 SHALL have port in_bit, input, 1 bit: systematic input bit, natural order.
REQ-005 SHALL have port in_length, input, 1 bit: block size select (0: K=1056, 1: K=6144), sampled on the first accepted bit.
REQ-006 SHALL have port in_ready, output, 1 bit: high only in IDLE/LOAD; bits are accepted only when in_valid and in_ready are both high.
REQ-007 SHALL have port data_valid, output, 1 bit: high for exactly K consecutive cycles per block.
REQ-008 SHALL have port ck, output, 1 bit: natural-order bit c(i).
REQ-009 SHALL have port ckp, output, 1 bit: interleaved bit c(pi(i)).
REQ-010 SHALL have port length, output, 1 bit: latched block-size flag, stable throughout EMIT.
REQ-011 SHALL have port busy, output, 1 bit: high in LOAD (after the first bit), EMIT and GAP.

Function
REQ-012 SHALL implement states IDLE, LOAD, EMIT and GAP.
REQ-013 IDLE -> LOAD SHALL occur on the first accepted bit; that bit is written to index 0 and in_length is latched.
REQ-014 LOAD SHALL write each accepted bit to buffer[wr_idx] and increment the 13-bit wr_idx.
  - in_valid low pauses LOAD with no state change.
REQ-015 LOAD -> EMIT SHALL occur on the cycle the bit at index K-1 is accepted; in_ready drops on the next cycle.
REQ-016 EMIT SHALL drive data_valid=1, ck=buffer[i], ckp=buffer[pi(i)] for i=0..K-1, one index per cycle, with outputs registered.
  - The first data_valid occurs 2 cycles after the last accepted bit.
REQ-017 pi(i) = (f1*i + f2*i^2) mod K, with (f1,f2) = (17,66) for K=1056 and (263,480) for K=6144.
REQ-018 pi SHALL be generated recursively, without multipliers:
  - pi(0)=0, g(0)=(f1+f2) mod K;
  - pi(i+1)=(pi(i)+g(i)) mod K, g(i+1)=(g(i)+2*f2) mod K;
  - each mod is a single conditional subtract of K on a 14-bit sum.
REQ-019 EMIT -> GAP SHALL occur after index K-1 is output; GAP lasts 1 cycle with data_valid=0; GAP -> IDLE follows.
REQ-020 in_valid during EMIT/GAP SHALL be ignored and SHALL NOT corrupt the buffer.
REQ-021 in_length changes after the first accepted bit SHALL be ignored until the next block.
REQ-022 ck/ckp SHALL be 0 whenever data_valid=0.

Reset
REQ-023 Asserting rst (low) in any state SHALL immediately force:
  - state IDLE, wr_idx=0, rd_idx=0, pi=0, g=0;
  - data_valid=0, ck=0, ckp=0, length=0, busy=0, in_ready=1.
REQ-024 A partially loaded or emitted block SHALL be discarded on reset; buffer contents need not be cleared.
REQ-025 The first accepted bit after rst deasserts SHALL be index 0 of a new block.

Configuration
REQ-026 With TURBO_INTLV_BYPASS_EN defined, the block SHALL add input port bypass (1 bit, sampled with in_length); when the sampled value is 1, ckp=ck for the whole block and timing is unchanged.
REQ-027 Without TURBO_INTLV_BYPASS_EN, the bypass port SHALL NOT exist and interleaving is always applied.

Structure
REQ-028 A shared package turbo_pkg SHALL hold:
  - the state enum;
  - K_SHORT=1056, K_LONG=6144;
  - F1/F2 constants for both sizes;
  - the index width of 13.
REQ-029 The address generator (pi/g recursion, mod-K subtract) SHALL be one sub-module, qpp_addr_gen; buffer and FSM stay in turbo_interleaver.

Verification
REQ-030 Scenario 1 -- reset check: load a K=1056 block with in_bit=1 only at index 83 -> ckp=1 at output cycle i=1 only (pi(1)=83); ck=1 at i=83 only.
REQ-031 Scenario 2 -- reset check: load a K=1056 block with a single 1 at index 298 -> ckp=1 at i=2 (pi(2)=298); data_valid high exactly 1056 cycles, then a 1-cycle gap.
REQ-032 Scenario 3 -- K=6144 random block: ckp sequence SHALL match a reference model computing (263*i+480*i^2) mod 6144 for all i; length=1 throughout.
REQ-033 Scenario 4 -- in_valid toggling 50% during LOAD, plus in_length flipped mid-block -> output identical to an unpaused load; length reflects the first-bit value.
REQ-034 Scenario 5 -- rst pulsed low at EMIT index 500 -> data_valid=0 immediately, in_ready=1; a fresh K=1056 block then emits correctly from i=0.
REQ-035 Scenario 6 -- TURBO_INTLV_BYPASS_EN defined, bypass=1 -> ckp==ck for every cycle of a K=1056 block.
